// File: rtl/a_bus_target.sv
// A_Bus slave: grants each request a fixed GNT_LATENCY edges after acceptance, serves a
// 128-byte register file over the shared data wire and keeps saturating transfer statistics.
module a_bus_target #(
  parameter int GNT_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [7:0]       addr,
  output logic             gnt,
  inout  wire  [7:0]       data,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] abort_count,
  output logic             busy
);

  if (GNT_LATENCY < 1 || GNT_LATENCY > 3) begin : g_latency_check
    $error("a_bus_target: GNT_LATENCY must be in 1..3");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam logic [1:0] WCNT_INIT = 2'(GNT_LATENCY - 1);

  state_t     state;
  logic [1:0] wcnt;
  logic [7:0] addr_q;
  logic       data_oe;
  logic [7:0] mem [128];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Control FSM; gnt, data_oe and busy are registered so they are glitch-free
  // for the whole GRANT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= 2'd0;
      gnt         <= 1'b0;
      data_oe     <= 1'b0;
      busy        <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
      abort_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            wcnt <= WCNT_INIT;
            busy <= 1'b1;
            if (WCNT_INIT == 2'd0) begin
              state   <= GRANT;
              gnt     <= 1'b1;
              data_oe <= addr[7];
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Master withdrew before grant, including on the edge that would have granted.
            state       <= IDLE;
            busy        <= 1'b0;
            abort_count <= sat_inc(abort_count);
          end else begin
            wcnt <= wcnt - 2'd1;
            if (wcnt == 2'd1) begin
              state   <= GRANT;
              gnt     <= 1'b1;
              data_oe <= addr_q[7];
            end
          end
        end
        GRANT: begin
          state   <= IDLE;
          gnt     <= 1'b0;
          data_oe <= 1'b0;
          busy    <= 1'b0;
          if (addr_q[7]) rd_count <= sat_inc(rd_count);
          else           wr_count <= sat_inc(wr_count);
        end
        default: begin
          state   <= IDLE;
          gnt     <= 1'b0;
          data_oe <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Address is captured only on acceptance; later changes while waiting are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) addr_q <= addr;
  end

  // Register file: write commits at the edge closing the GRANT cycle; reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
    end else if (state == GRANT && !addr_q[7]) begin
      mem[addr_q[6:0]] <= data;
    end
  end

  assign data = data_oe ? mem[addr_q[6:0]] : 8'hzz;

endmodule

// File: tb/tb_a_bus_target.sv
// Scoreboard bench for a_bus_target: five instances (latency 1/2/2/3 and a 4-bit counter
// variant) driven with directed and random transfers against a behavioural model.
`timescale 1ns/1ps
module tb_a_bus_target;
  localparam int N = 5;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int cmax(input int i);
    return (i == 4) ? 15 : 65535;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, req, drv_en, gnt, busy, oe;
  logic [7:0]   addr [N];
  logic [7:0]   drv  [N];
  logic [7:0]   dat  [N];
  logic [15:0]  rdc  [N];
  logic [15:0]  wrc  [N];
  logic [15:0]  abc  [N];

  for (genvar i = 0; i < N; i++) begin : g
    localparam int L  = lat_of(i);
    localparam int CW = (i == 4) ? 4 : 16;
    wire  [7:0]    data;
    logic [CW-1:0] rd_l, wr_l, ab_l;
    logic          gnt_l, busy_l;
    assign data = drv_en[i] ? drv[i] : 8'hzz;
    a_bus_target #(.GNT_LATENCY(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst[i]), .req(req[i]), .addr(addr[i]), .gnt(gnt_l),
      .data(data), .rd_count(rd_l), .wr_count(wr_l), .abort_count(ab_l), .busy(busy_l)
    );
    assign gnt[i]  = gnt_l;
    assign busy[i] = busy_l;
    assign oe[i]   = dut.data_oe;
    assign dat[i]  = data;
    assign rdc[i]  = 16'(rd_l);
    assign wrc[i]  = 16'(wr_l);
    assign abc[i]  = 16'(ab_l);
  end

  // Behavioural reference: plain memory image and transfer tallies per instance.
  logic [7:0] model [N][128];
  int mrd [N], mwr [N], mab [N];
  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int inst; bit rnw; logic [7:0] d; int due; } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int j = 0; j < 128; j++) model[k][j] = 8'h00;
    mrd[k] = 0; mwr[k] = 0; mab[k] = 0;
  endtask

  // Monitor: every grant pops one expected transfer and checks owner, timing and read data.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected: inst %0d granted at cycle %0d, required no grant", i, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          checks++;
          if (e.inst != i || e.due != cyc) begin
            errors++;
            $display("FAIL gnt_timing: inst %0d cycle %0d, required inst %0d cycle %0d", i, cyc, e.inst, e.due);
          end
          if (e.rnw) begin
            checks++;
            if (dat[i] !== e.d) begin
              errors++;
              $display("FAIL rd_data: inst %0d data %h, required %h", i, dat[i], e.d);
            end
          end
        end
      end
    end
  end

  // Raise a request, push its expected response, return right after the grant was sampled.
  task automatic issue(input int k, input bit rnw, input logic [6:0] idx, input logic [7:0] wd,
                       output bit ok);
    exp_t e;
    int   n;
    req[k]  = 1'b1;
    addr[k] = {rnw, idx};
    if (!rnw) begin drv[k] = wd; drv_en[k] = 1'b1; end
    e.inst = k; e.rnw = rnw; e.d = rnw ? model[k][idx] : wd; e.due = cyc + lat_of(k);
    q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[k] && n < 8);
    ok = gnt[k];
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: inst %0d no grant within 8 cycles, required grant", k);
    end
  endtask

  task automatic xfer(input int k, input bit rnw, input logic [6:0] idx, input logic [7:0] wd,
                      input bit keep);
    bit ok;
    issue(k, rnw, idx, wd, ok);
    @(posedge clk); #1;
    drv_en[k] = 1'b0;
    if (!keep) req[k] = 1'b0;
    if (ok) begin
      if (rnw) mrd[k] = (mrd[k] + 1 > cmax(k)) ? cmax(k) : mrd[k] + 1;
      else begin
        mwr[k] = (mwr[k] + 1 > cmax(k)) ? cmax(k) : mwr[k] + 1;
        model[k][idx] = wd;
      end
    end
  endtask

  // Assert reset during the GRANT cycle: the transfer must vanish without side effects.
  task automatic rst_in_grant(input int k, input bit rnw, input logic [6:0] idx, input logic [7:0] wd);
    bit ok;
    issue(k, rnw, idx, wd, ok);
    rst[k] = 1'b1;
    req[k] = 1'b0;
    @(posedge clk); #1;
    rst[k]    = 1'b0;
    drv_en[k] = 1'b0;
    model_reset(k);
    chk($sformatf("rst_mid_gnt_%0d", k), 16'(gnt[k]), 16'd0);
    chk($sformatf("rst_mid_oe_%0d", k), 16'(oe[k]), 16'd0);
    chk($sformatf("rst_mid_busy_%0d", k), 16'(busy[k]), 16'd0);
    chk($sformatf("rst_mid_wr_%0d", k), wrc[k], 16'd0);
    chk($sformatf("rst_mid_rd_%0d", k), rdc[k], 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ks [20];
    logic [6:0] lastw;
    logic [6:0] idx;
    bit         rnw, keep;

    rst = '1; req = '0; drv_en = '0;
    for (int k = 0; k < N; k++) begin
      addr[k] = 8'h00; drv[k] = 8'h00; model_reset(k);
    end
    repeat (3) @(posedge clk);
    #1 rst = '0;

    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_gnt_%0d", k), 16'(gnt[k]), 16'd0);
      chk($sformatf("reset_busy_%0d", k), 16'(busy[k]), 16'd0);
      chk($sformatf("reset_oe_%0d", k), 16'(oe[k]), 16'd0);
      chk($sformatf("reset_rd_%0d", k), rdc[k], 16'd0);
      chk($sformatf("reset_wr_%0d", k), wrc[k], 16'd0);
      chk($sformatf("reset_ab_%0d", k), abc[k], 16'd0);
    end

    // Write then read back.
    xfer(1, 1'b0, 7'h05, 8'hA5, 1'b0);
    xfer(1, 1'b1, 7'h05, 8'h00, 1'b0);
    chk("wr_readback_wr_count", wrc[1], 16'd1);
    chk("wr_readback_rd_count", rdc[1], 16'd1);

    // Latency sweep: single read on latency 1, 2 and 3 instances.
    xfer(0, 1'b1, 7'h10, 8'h00, 1'b0);
    xfer(2, 1'b1, 7'h11, 8'h00, 1'b0);
    xfer(3, 1'b1, 7'h12, 8'h00, 1'b0);
    xfer(0, 1'b0, 7'h20, 8'h5F, 1'b1);
    xfer(0, 1'b1, 7'h20, 8'h00, 1'b0);

    // Abort on latency 3: request withdrawn on the edge that would have granted.
    req[3] = 1'b1; addr[3] = 8'h09; drv[3] = 8'h77; drv_en[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1 req[3] = 1'b0; drv_en[3] = 1'b0;
    mab[3]++;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", 16'(busy[3]), 16'd0);
    chk("abort_count", abc[3], 16'(mab[3]));
    chk("abort_wr_count", wrc[3], 16'(mwr[3]));
    xfer(3, 1'b1, 7'h09, 8'h00, 1'b0);

    // Back-to-back random traffic across two latency-2 instances.
    for (int i = 0; i < 20; i++) ks[i] = 1 + int'($urandom_range(0, 1));
    lastw = 7'h00;
    for (int i = 0; i < 20; i++) begin
      rnw  = (i % 2) == 1;
      idx  = 7'($urandom_range(0, 127));
      if (rnw && $urandom_range(0, 3) != 0) idx = lastw;
      if (!rnw) lastw = idx;
      keep = (i < 19) && (ks[i + 1] == ks[i]);
      xfer(ks[i], rnw, idx, 8'($urandom), keep);
    end
    for (int k = 1; k <= 2; k++) begin
      chk($sformatf("b2b_rd_count_%0d", k), rdc[k], 16'(mrd[k]));
      chk($sformatf("b2b_wr_count_%0d", k), wrc[k], 16'(mwr[k]));
    end

    // Reset in the GRANT cycle of a write, then of a read.
    rst_in_grant(2, 1'b0, 7'h07, 8'h3C);
    xfer(2, 1'b1, 7'h07, 8'h00, 1'b0);
    xfer(2, 1'b0, 7'h03, 8'h5A, 1'b0);
    rst_in_grant(2, 1'b1, 7'h03, 8'h00);
    xfer(2, 1'b1, 7'h03, 8'h00, 1'b0);

    // Saturation on the 4-bit counter instance.
    xfer(4, 1'b0, 7'h44, 8'hC3, 1'b0);
    for (int i = 0; i < 20; i++) xfer(4, 1'b1, 7'h44, 8'h00, i < 19);
    chk("sat_rd_count", rdc[4], 16'h000F);
    chk("sat_rd_model", rdc[4], 16'(mrd[4]));

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("final_rd_%0d", k), rdc[k], 16'(mrd[k]));
      chk($sformatf("final_wr_%0d", k), wrc[k], 16'(mwr[k]));
      chk($sformatf("final_ab_%0d", k), abc[k], 16'(mab[k]));
      chk($sformatf("final_busy_%0d", k), 16'(busy[k]), 16'd0);
    end
    chk("scoreboard_empty", 16'(q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a_bus_target.md
# a_bus_target

Synchronous A_Bus slave that sits directly downstream of the bus interface's device-side port: it accepts requests (`req`, `addr`), answers each with a one-cycle `gnt` pulse a fixed 1–3 clocks later, and moves a byte over the shared bidirectional `data` wire. It has a 128-byte register file and counts completed reads, completed writes and aborted requests. It is the device-under-test companion for the synchronous testbench, whose property is `req ##[1:3] gnt`.

## Interface
- `GNT_LATENCY`, default 2: number of edges from request acceptance to the edge where `gnt` is sampled high. Legal range 1..3; elaboration error otherwise.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: single clock; all logic on `posedge clk`.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  1: request from the master; held until `gnt` is seen.
- `addr`  in  8: `addr[7]` = 1 means read, 0 means write; `addr[6:0]` is the register index.
- `gnt`  out  1: grant pulse, registered.
- `data`  inout  8: shared data wire.
  - Driven by the target only when `data_oe` is high; otherwise `'z`.
- `rd_count`  out  `CNT_W`: completed reads, saturating.
- `wr_count`  out  `CNT_W`: completed writes, saturating.
- `abort_count`  out  `CNT_W`: requests withdrawn before grant, saturating.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, WAIT, GRANT.
- **IDLE**
  - If `req` is sampled 1, latch `addr` into `addr_q` and load `wcnt` = `GNT_LATENCY`-1.
  - Go to GRANT if `wcnt` = 0, else go to WAIT.
- **WAIT**
  - If `req` is sampled 0, the request is aborted: return to IDLE and increment `abort_count`.
  - Otherwise decrement `wcnt`; go to GRANT when it reaches 0.
  - `addr` changes during WAIT are ignored; `addr_q` is used.
- **GRANT** (exactly one cycle)
  - `gnt` = 1.
  - Read (`addr_q[7]` = 1): `data_oe` = 1 and `data` = `mem[addr_q[6:0]]` for this whole cycle.
  - Write: at the closing edge, `mem[addr_q[6:0]]` <= sampled `data`.
  - Increment `rd_count` or `wr_count`.
  - Always return to IDLE.
- **Back-to-back requests**: if `req` is still 1 in the IDLE cycle after GRANT, it is a new transaction. The master must drop `req` at the edge where it samples `gnt` unless it intends another transfer. Minimum spacing is therefore `GNT_LATENCY`+1 edges per transfer.
- **Counters**: saturate at all-ones and never wrap.
- **Write data**: the master drives `data` for writes; the target never drives it on a write.

## Timing
- **Reset values**
  - `gnt` = 0, `data_oe` = 0 (`data` released to `'z`), `busy` = 0.
  - All counters = 0, state = IDLE, all `mem` entries = 8'h00.
- **Latency**: with `req` first sampled 1 in IDLE at edge n, `gnt` is sampled 1 at edge n+`GNT_LATENCY` and 0 at edge n+`GNT_LATENCY`+1. This satisfies `req ##[1:3] gnt`.
- **Read data**: valid on `data` in the same cycle as `gnt` and sampled by the master at the same edge. Released at the following edge.
- **Write commit**: the write is visible to a read that is granted 2 or more edges later.
- **Reset mid-operation**
  - Reset wins over everything at the edge where `rst` = 1.
  - A pending WAIT or GRANT is dropped with no counter update and no memory write.
  - `gnt` and `data_oe` are 0 from the next cycle.
- **Aborts**
  - `req` falling in the same edge that would move WAIT to GRANT counts as an abort; no `gnt` is issued.
  - With `GNT_LATENCY` = 1 an abort is impossible: IDLE goes directly to GRANT.

## Test plan
- **Reset, write, read back**: reset, write 8'hA5 to `addr` 8'h05, then read `addr` 8'h85.
  - Required: `data` = 8'hA5 at the `gnt` edge, `wr_count` = 1, `rd_count` = 1.
- **Latency sweep**: elaborate with `GNT_LATENCY` = 1, 2 and 3 and issue a single read.
  - Required: `gnt` is sampled exactly 1, 2 and 3 edges after `req`, is 1 cycle wide, and the SVA `req ##[1:3] gnt` passes.
- **Abort** (`GNT_LATENCY` = 3): raise `req` for 2 edges, then drop it.
  - Required: no `gnt`, `abort_count` = 1, memory unchanged, `busy` returns to 0.
- **Back-to-back, random selection**: 20 transfers with `req` held continuously, alternating write/read to random addresses, with two target instances on the same clock selected at random per transfer.
  - Required: every read returns the last value written to that index, and the counts match exactly.
- **Reset mid-transfer**: assert `rst` in the GRANT cycle of a write of 8'h3C to index 7.
  - Required: index 7 still reads 8'h00, `wr_count` = 0, and `data` is `'z` the next cycle.
- **Saturation** (`CNT_W` = 4): perform 20 reads.
  - Required: `rd_count` holds at 4'hF.
